// File: rtl/grf_pkg.sv
// Shared widths and pending-counter saturation helpers for the multiport GRF.
`timescale 1ns/1ps
package grf_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int PEND_W_DEF = 2;
    localparam int PEND_MAX   = (1 << PEND_W_DEF) - 1;

    function automatic int pend_max(input int w);
        return (1 << w) - 1;
    endfunction
endpackage

// File: rtl/grf_pend_cnt.sv
// Per-register outstanding-write counter; flags overflow/underflow attempts instead of wrapping.
`timescale 1ns/1ps
module grf_pend_cnt
    import grf_pkg::*;
#(
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] count,
    output logic              busy,
    output logic              full,
    output logic              err_pulse
);
    localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(pend_max(PEND_W));
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [PEND_W-1:0] r_count;
    logic [PEND_W-1:0] w_next;
    logic              w_zero;

    assign w_zero = (r_count == '0);
    assign full   = (r_count == CNT_MAX);
    assign count  = r_count;
    // A write retiring the last reservation makes the bypassed value final.
    assign busy   = !w_zero && !(dec && !inc && (r_count == CNT_ONE));

    always_comb begin
        w_next    = r_count;
        err_pulse = 1'b0;
        if (inc && !dec) begin
            if (full) err_pulse = 1'b1;
            else      w_next    = r_count + CNT_ONE;
        end else if (dec && !inc) begin
            if (w_zero) err_pulse = 1'b1;
            else        w_next    = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_count <= '0;
        else        r_count <= w_next;
    end
endmodule

// File: rtl/grf_multiport.sv
// Multiport general register file with write bypass and a pending-write scoreboard.
`timescale 1ns/1ps
module grf_multiport
    import grf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic [31:0]              wpc0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [31:0]              wpc1,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    output logic                     err
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic              r_err;
    logic              w_we0;
    logic              w_we1;
    logic [NREG-1:0]   w_inc;
    logic [NREG-1:0]   w_dec;
    logic [NREG-1:0]   w_busy;
    logic [NREG-1:0]   w_full;
    logic [NREG-1:0]   w_errp;
    logic [PEND_W-1:0] w_count [NREG];

    // Port 0 wins a same-address collision, so port 1 is not effective then.
    assign w_we0 = we0 && (waddr0 != '0);
    assign w_we1 = we1 && (waddr1 != '0) && !(w_we0 && (waddr1 == waddr0));

    assign w_inc[0]   = 1'b0;
    assign w_dec[0]   = 1'b0;
    assign w_busy[0]  = 1'b0;
    assign w_full[0]  = 1'b0;
    assign w_errp[0]  = 1'b0;
    assign w_count[0] = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_pend
        assign w_inc[i] = iss_en && (iss_addr == ADDR_W'(i));
        assign w_dec[i] = (w_we0 && (waddr0 == ADDR_W'(i))) ||
                          (w_we1 && (waddr1 == ADDR_W'(i)));
        grf_pend_cnt #(.PEND_W(PEND_W)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (w_inc[i]),
            .dec       (w_dec[i]),
            .count     (w_count[i]),
            .busy      (w_busy[i]),
            .full      (w_full[i]),
            .err_pulse (w_errp[i])
        );
    end

    assign iss_ready = !(w_full[iss_addr] && !w_dec[iss_addr]);
    assign err       = r_err;

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] v_ra;
            v_ra       = rd_addr[k*ADDR_W +: ADDR_W];
            rd_busy[k] = w_busy[v_ra];
            if (v_ra == '0)
                rd_data[k*DATA_W +: DATA_W] = '0;
            else if (we0 && (v_ra == waddr0))
                rd_data[k*DATA_W +: DATA_W] = wdata0;
            else if (we1 && (v_ra == waddr1))
                rd_data[k*DATA_W +: DATA_W] = wdata1;
            else
                rd_data[k*DATA_W +: DATA_W] = r_regs[v_ra];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_we0) r_regs[waddr0] <= wdata0;
            if (w_we1) r_regs[waddr1] <= wdata1;
            r_err <= r_err | (|w_errp);
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset) begin
            if (w_we0)
                $display("%0t grf wr0 pc=%h addr=%0d data=%h pend=%0d", $time, wpc0, waddr0, wdata0, w_count[waddr0]);
            if (w_we1)
                $display("%0t grf wr1 pc=%h addr=%0d data=%h pend=%0d", $time, wpc1, waddr1, wdata1, w_count[waddr1]);
        end
    end
`endif
endmodule
